// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared encodings for the multiply/divide unit.
//   - SELECT op codes. These are the M-extension codes, 5 bits wide, of the
//     form {2'b01, funct3}.
//   - FSM state constants.
//   - Small decode helpers that work on the op code only.
// Build option (used in muldiv_unit): MULDIV_EARLY_OUT_EN.
package muldiv_unit_pkg;

  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_MUL  = 2'd1,
    CLS_DIV  = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    if (op[4:2] == 3'b010) return CLS_MUL;
    if (op[4:2] == 3'b011) return CLS_DIV;
    return CLS_NONE;
  endfunction

  // MUL (00) and MULH (01) are signed x signed.
  // MULHSU (10) is signed x unsigned. MULHU (11) is unsigned x unsigned.
  function automatic logic mul_a_signed(input logic [4:0] op);
    return op[1:0] != 2'b11;
  endfunction

  function automatic logic mul_b_signed(input logic [4:0] op);
    return !op[1];
  endfunction

  function automatic logic mul_high(input logic [4:0] op);
    return op[1:0] != 2'b00;
  endfunction

  // DIV/REM are signed (op[0]=0). REM/REMU return the remainder (op[1]=1).
  function automatic logic div_signed(input logic [4:0] op);
    return !op[0];
  endfunction

  function automatic logic div_rem(input logic [4:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// muldiv_div_iter: restoring divider. It produces one quotient bit per cycle.
// Timing:
//   - start arms the unit.
//   - The next cycle is setup. It samples dividend, divisor and is_signed, and
//     loads the operand magnitudes. These inputs must be stable through that
//     cycle.
//   - XLEN iterations follow.
// done is high during the final iteration cycle. In that cycle quotient and
// remainder show the finished, sign-corrected values. The owner captures them
// on that edge.
// Ports: clk, rst_n (async, active low), start, kill (abandon), is_signed,
//        dividend, divisor, done, quotient, remainder.
module muldiv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN) + 1;

  logic            setup_q, setup_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic            negq_q, negq_d, negr_q, negr_d;

  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] iter_rem, iter_quo;
  logic            a_neg, b_neg;

  always_comb begin
    // One restoring step.
    // Shift the next dividend bit into the partial remainder.
    // Keep the difference only if it did not go negative.
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    diff     = rem_sh - {1'b0, dvs_q};
    iter_rem = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    iter_quo = {quo_q[XLEN-2:0], ~diff[XLEN]};

    a_neg = is_signed & dividend[XLEN-1];
    b_neg = is_signed & divisor[XLEN-1];

    setup_d = setup_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;

    if (kill) begin
      setup_d = 1'b0;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = '0;
    end else if (start) begin
      setup_d = 1'b1;
    end else if (setup_q) begin
      setup_d = 1'b0;
      quo_d   = a_neg ? -dividend : dividend;
      dvs_d   = b_neg ? -divisor : divisor;
      rem_d   = '0;
      cnt_d   = CW'(XLEN);
      negq_d  = a_neg ^ b_neg;
      negr_d  = a_neg;
    end else if (cnt_q != '0) begin
      rem_d = iter_rem;
      quo_d = iter_quo;
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign done      = (cnt_q == CW'(1));
  assign quotient  = negq_q ? -iter_quo : iter_quo;
  assign remainder = negr_q ? -iter_rem : iter_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setup_q <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      setup_q <= setup_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: M-extension multiply/divide unit. It handles one operation at
// a time.
// Handshakes (valid/ready):
//   - A request is taken when IN_VALID && IN_READY.
//   - A result is held with OUT_VALID until OUT_READY is high.
//   - FLUSH aborts any operation.
//   - RESULT is 0 whenever OUT_VALID is low.
// Ports:
//   - CLK, RESETN (async, active low)
//   - IN_VALID/IN_READY, SELECT, DATA1, DATA2, FLUSH
//   - OUT_VALID/OUT_READY, RESULT, BUSY
// Build option: MULDIV_EARLY_OUT_EN. When defined, divide-by-zero and signed
// overflow finish one cycle after accept.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic div_special(input logic [4:0] op,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    return (b == '0) || (div_signed(op) && (a == MIN_NEG) && (b == '1));
  endfunction

  logic [1:0]      state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic            quick_q, quick_d;
  logic [2:0]      mul_cnt_q, mul_cnt_d;
  logic [XLEN-1:0] mul_pipe_q [MUL_STAGES];
  logic [XLEN-1:0] mul_pipe_d [MUL_STAGES];
  logic [XLEN-1:0] result_q, result_d;

  logic            accept, div_start, div_done;
  logic [XLEN-1:0] div_quo, div_rem_v, special_res;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [XLEN-1:0] mul_res_in;

  assign IN_READY  = (state_q == ST_IDLE) && !FLUSH;
  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = (state_q == ST_DONE);
  assign BUSY      = (state_q != ST_IDLE);
  assign RESULT    = result_q;

  // Product of the incoming operands. Both operands are extended to 2*XLEN,
  // so one multiplier covers every signedness mix.
  always_comb begin
    ext_a      = {{XLEN{mul_a_signed(SELECT) & DATA1[XLEN-1]}}, DATA1};
    ext_b      = {{XLEN{mul_b_signed(SELECT) & DATA2[XLEN-1]}}, DATA2};
    prod       = ext_a * ext_b;
    mul_res_in = mul_high(SELECT) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  // Architectural results for divide-by-zero and signed overflow.
  always_comb begin
    if (div_rem(op_q)) special_res = (b_q == '0) ? a_q : '0;
    else               special_res = (b_q == '0) ? '1 : MIN_NEG;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic early_in;
  assign early_in = div_special(SELECT, DATA1, DATA2);
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    quick_d    = quick_q;
    mul_cnt_d  = mul_cnt_q;
    mul_pipe_d = mul_pipe_q;
    result_d   = result_q;
    div_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = SELECT;
          a_d     = DATA1;
          b_d     = DATA2;
          quick_d = 1'b0;
          case (op_class(SELECT))
            CLS_MUL: begin
              state_d       = ST_MUL;
              mul_cnt_d     = 3'd1;
              mul_pipe_d[0] = mul_res_in;
            end
            CLS_DIV: begin
              state_d = ST_DIV;
`ifdef MULDIV_EARLY_OUT_EN
              if (early_in) quick_d   = 1'b1;
              else          div_start = 1'b1;
`else
              div_start = 1'b1;
`endif
            end
            default: begin
              // Non-M codes take the one-cycle quick path and return 0.
              state_d = ST_DIV;
              quick_d = 1'b1;
            end
          endcase
        end
      end
      ST_MUL: begin
        for (int i = 1; i < MUL_STAGES; i++) mul_pipe_d[i] = mul_pipe_q[i-1];
        if (mul_cnt_q == 3'(MUL_STAGES)) begin
          state_d   = ST_DONE;
          mul_cnt_d = 3'd0;
          result_d  = mul_pipe_q[MUL_STAGES-1];
        end else begin
          mul_cnt_d = mul_cnt_q + 3'd1;
        end
      end
      ST_DIV: begin
        if (quick_q) begin
          state_d  = ST_DONE;
          quick_d  = 1'b0;
          result_d = (op_class(op_q) == CLS_DIV) ? special_res : '0;
        end else if (div_done) begin
          // Final iteration edge. The divider outputs are already
          // sign-corrected. Special cases override them.
          state_d = ST_DONE;
          if (div_special(op_q, a_q, b_q)) result_d = special_res;
          else result_d = div_rem(op_q) ? div_rem_v : div_quo;
        end
      end
      default: begin
        if (OUT_READY) begin
          state_d  = ST_IDLE;
          result_d = '0;
        end
      end
    endcase

    if (FLUSH) begin
      state_d   = ST_IDLE;
      result_d  = '0;
      quick_d   = 1'b0;
      mul_cnt_d = 3'd0;
      div_start = 1'b0;
    end
  end

  muldiv_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (CLK),
    .rst_n     (RESETN),
    .start     (div_start),
    .kill      (FLUSH),
    .is_signed (div_signed(op_q)),
    .dividend  (a_q),
    .divisor   (b_q),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem_v)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quick_q   <= 1'b0;
      mul_cnt_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) mul_pipe_q[i] <= '0;
      result_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      quick_q    <= quick_d;
      mul_cnt_q  <= mul_cnt_d;
      mul_pipe_q <= mul_pipe_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (XLEN=32, MUL_STAGES=2).
// It also runs hand sequences for hold, flush, reset and retire.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = XLEN + 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPC_LAT = 1;
`else
  localparam int SPC_LAT = XLEN + 1;
`endif

  logic            clk, rst_n, in_valid, in_ready, flush;
  logic            out_valid, out_ready, busy;
  logic [4:0]      sel;
  logic [XLEN-1:0] data1, data2, result;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    string           name;
    logic [4:0]      sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;
  vec_t vecs[$];

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
    .CLK       (clk),
    .RESETN    (rst_n),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .SELECT    (sel),
    .DATA1     (data1),
    .DATA2     (data2),
    .FLUSH     (flush),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .RESULT    (result),
    .BUSY      (busy)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [4:0] s, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] e, input int l);
    vec_t v;
    v.name = n; v.sel = s; v.a = a; v.b = b; v.exp = e; v.lat = l;
    vecs.push_back(v);
  endtask

  // Driver: must be called 1 time unit after a rising edge. It returns 1 time
  // unit after the accept edge.
  task automatic issue(input string n, input logic [4:0] s, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b);
    sel = s; data1 = a; data2 = b; in_valid = 1'b1;
    check({n, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: wait for OUT_VALID.
  //   - Compare RESULT against the head of exp_q.
  //   - Compare edges since accept against the expected latency.
  //   - While waiting, RESULT must stay 0.
  task automatic wait_result(input string n, input int exp_lat);
    int lat = 0;
    logic iso_bad = 1'b0;
    logic [XLEN-1:0] e;
    if (result !== '0) iso_bad = 1'b1;
    for (int c = 1; c <= 100 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (out_valid) lat = c;
      else if (result !== '0) iso_bad = 1'b1;
    end
    e = exp_q.pop_front();
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no OUT_VALID expected one within 100 cycles", n);
    end else begin
      check({n, "_result"}, 64'(result), 64'(e));
      check({n, "_latency"}, 64'(lat), 64'(exp_lat));
    end
    check({n, "_isolation"}, 64'(iso_bad), 64'(0));
  endtask

  task automatic retire(input string n);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({n, "_retire_valid"}, 64'(out_valid), 64'(0));
    check({n, "_retire_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    sel = '0; data1 = '0; data2 = '0;

    add_vec("mul_7x-3",     OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    add_vec("mulhu_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    add_vec("mulhsu_m1",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
    add_vec("mulh_minsq",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    add_vec("mulh_-2x3",    OP_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, MUL_LAT);
    add_vec("mul_shift",    OP_MUL,    32'h12345678, 32'h10,       32'h23456780, MUL_LAT);
    add_vec("div_-7_2",     OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
    add_vec("rem_-7_2",     OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
    add_vec("div_7_-2",     OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
    add_vec("rem_7_-2",     OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT);
    add_vec("remu_100_7",   OP_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT);
    add_vec("divu_min_m1",  OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        DIV_LAT);
    add_vec("div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT);
    add_vec("rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SPC_LAT);
    add_vec("divu_5_0",     OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT);
    add_vec("rem_5_0",      OP_REM,    32'd5,        32'd0,        32'd5,        SPC_LAT);
    add_vec("div_-5_0",     OP_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPC_LAT);
    add_vec("non_m",        5'b00000,  32'd9,        32'd4,        32'd0,        1);

    // Reset state.
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      issue(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b);
      wait_result(vecs[i].name, vecs[i].lat);
      retire(vecs[i].name);
    end

    // Hold the result for 10 cycles while a new request waits.
    exp_q.push_back(32'hFFFFFFEB);
    issue("hold", OP_MUL, 32'd7, 32'hFFFFFFFD);
    wait_result("hold", MUL_LAT);
    sel = OP_MUL; data1 = 32'd2; data2 = 32'd2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_result", 64'(result), 64'(32'hFFFFFFEB));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    // Pulse OUT_READY with IN_VALID still high: the unit retires and must not
    // accept in the same cycle.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("hold_retire_valid", 64'(out_valid), 64'(0));
    check("hold_retire_result", 64'(result), 64'(0));
    check("hold_retire_busy", 64'(busy), 64'(0));
    check("hold_retire_in_ready", 64'(in_ready), 64'(1));

    // FLUSH at iteration 10 of a divide, with IN_VALID high.
    issue("flush_div", OP_DIV, 32'd1000, 32'd3);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; sel = OP_MUL;
    check("flush_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_valid", 64'(out_valid), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    check("flush_no_result", 64'(seen), 64'(0));

    // Reset pulse during a multiply.
    issue("rst_mul", OP_MUL, 32'd3, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 64'(seen), 64'(0));

    // The first divide after the reset.
    exp_q.push_back(32'd14);
    issue("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    wait_result("divu_100_7", DIV_LAT);
    retire("divu_100_7");

    // FLUSH while a result is pending in DONE.
    exp_q.push_back(32'd42);
    issue("flush_done", OP_MUL, 32'd6, 32'd7);
    wait_result("flush_done", MUL_LAT);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done_valid", 64'(out_valid), 64'(0));
    check("flush_done_result", 64'(result), 64'(0));
    check("flush_done_busy", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, 32, operand and result width in bits (legal: 32 or 64).
REQ-002 Parameter MUL_STAGES, 2, multiply latency in cycles from accept to OUT_VALID (legal: 1-4).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESETN  input  1  asynchronous active-low reset.
REQ-005 IN_VALID  input  1  operation request valid.
REQ-006 IN_READY  output  1  unit can accept a request this cycle.
REQ-007 SELECT  input  5  operation code, same 5-bit M-extension encodings as the existing ALU (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-008 DATA1  input  XLEN  operand rs1.
REQ-009 DATA2  input  XLEN  operand rs2.
REQ-010 FLUSH  input  1  kill in-flight operation (pipeline squash).
REQ-011 OUT_VALID  output  1  RESULT valid.
REQ-012 OUT_READY  input  1  consumer accepts RESULT.
REQ-013 RESULT  output  XLEN  operation result.
REQ-014 BUSY  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, MUL, DIV, DONE; one operation in flight at a time.
REQ-016 IN_READY = (state==IDLE) && !FLUSH; accept = IN_VALID && IN_READY; SELECT, DATA1 and DATA2 are registered on accept.
REQ-017 On accept of MUL* the unit enters MUL and enters DONE MUL_STAGES cycles later; OUT_VALID rises on the accept edge + MUL_STAGES.
REQ-018 On accept of DIV* the unit enters DIV: 1 setup cycle (operand magnitudes) + XLEN restoring iterations (1 quotient bit/cycle), then DONE; OUT_VALID at accept edge + XLEN + 1, sign fixup applied on the DIV->DONE transition.
REQ-019 On accept of a non-M SELECT the unit enters DONE on the next edge with RESULT = 0.
REQ-020 MUL: low XLEN bits of the signed product. MULH: high XLEN bits, signed x signed. MULHSU: high bits, signed x unsigned. MULHU: high bits, unsigned x unsigned. All products are computed at 2*XLEN width.
REQ-021 DIV and REM truncate toward zero; the REM result takes the sign of the dividend.
REQ-022 Divisor zero: DIV/DIVU give all-ones; REM/REMU give DATA1.
REQ-023 Signed overflow (DATA1 = most negative, DATA2 = all-ones): DIV gives most negative; REM gives 0.
REQ-024 In DONE: OUT_VALID held high and RESULT held stable until OUT_READY; on OUT_READY the unit returns to IDLE the next edge; no new request is accepted in the same cycle.
REQ-025 FLUSH in any state: the next state is IDLE and OUT_VALID is low the next cycle; the pending result is discarded; FLUSH together with IN_VALID means the request is not accepted.
REQ-026 RESULT = 0 whenever OUT_VALID is low (operand isolation, no toggling).

Reset
REQ-027 RESETN low forces, asynchronously: state IDLE, OUT_VALID 0, RESULT 0, BUSY 0, and all iteration counters and partial-remainder registers 0.
REQ-028 Reset mid-operation abandons the operation; the first accept after RESETN deasserts behaves as from power-up.

Configuration
REQ-029 Macro MULDIV_EARLY_OUT_EN defined: divisor-zero and signed-overflow DIV* requests go from accept to DONE in 1 cycle (OUT_VALID at accept edge + 1).
REQ-030 Macro not defined: those cases take the full XLEN + 1 cycles; the results are identical to REQ-022/023.

Structure
REQ-031 The shared encodings include file holds the SELECT op codes and the FSM state constants; muldiv_unit defines no op-code values locally.
REQ-032 The divider datapath is a single sub-module, muldiv_div_iter (start, operands, signed flag, done, quotient, remainder); the multiplier is inline with a MUL_STAGES-deep result shift register.

Verification
REQ-033 MUL 7 x -3 (XLEN=32) -> RESULT 0xFFFFFFEB, OUT_VALID exactly 2 cycles after accept.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 DIV -7 / 2 -> 0xFFFFFFFD and REM -7 / 2 -> 0xFFFFFFFF, each with OUT_VALID at cycle 33.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; latency 1 with MULDIV_EARLY_OUT_EN defined, 33 without.
REQ-037 Hold OUT_READY low 10 cycles after a result -> RESULT and OUT_VALID stable and IN_READY low throughout; OUT_READY pulse -> IDLE the next cycle.
REQ-038 FLUSH at DIV iteration 10, then RESETN pulse during a MUL -> no OUT_VALID from either; the next DIVU 100/7 -> 14.
